// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: NBANK x UNIT_NBIT GPIO bank controller (masked writes, synchronised read-back, timed pulses).
// Latency: write/error response 1 cycle after accept, read 2 cycles, pulse max(len,1)+1 cycles.
// Backpressure: cmd_rdy high only in IDLE; source holds cmd_vd until accepted. Pulse op built only with IOBANK_PULSE_EN.
module io_bank_ctrl #(
    parameter int NBANK       = 4,
    parameter int UNIT_NBIT   = 16,
    parameter int BANK_NBIT   = 2,
    parameter int PULSE_NBIT  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_vd,
    output logic                       cmd_rdy,
    input  logic [1:0]                 cmd_op,
    input  logic [BANK_NBIT-1:0]       cmd_bank,
    input  logic [UNIT_NBIT-1:0]       cmd_msk,
    input  logic [UNIT_NBIT-1:0]       cmd_dir,
    input  logic [UNIT_NBIT-1:0]       cmd_db,
    input  logic [PULSE_NBIT-1:0]      cmd_len,
    output logic                       rsp_vd,
    output logic                       rsp_err,
    output logic [UNIT_NBIT-1:0]       rsp_db,
    output logic [NBANK*UNIT_NBIT-1:0] io_oe,
    output logic [NBANK*UNIT_NBIT-1:0] io_out,
    input  logic [NBANK*UNIT_NBIT-1:0] io_in
);
    localparam int PINS = NBANK * UNIT_NBIT;
    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;

    typedef enum logic [1:0] {IDLE, RD, PULSE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [PINS-1:0]        oe_q, oe_d, out_q, out_d;
    logic [PINS-1:0]        sync_q [SYNC_STAGES];
    logic [BANK_NBIT-1:0]   bank_q, bank_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [UNIT_NBIT-1:0]   rsp_db_q, rsp_db_d;

    logic                   accept, bank_bad;
    logic [UNIT_NBIT-1:0]   cur_oe, cur_out, wr_oe, wr_out, sync_bank;

    assign cmd_rdy   = (state_q == IDLE) && !rst;
    assign accept    = cmd_vd && cmd_rdy;
    assign bank_bad  = int'(cmd_bank) >= NBANK;
    assign cur_oe    = oe_q[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT];
    assign cur_out   = out_q[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT];
    assign wr_oe     = (cur_oe & ~cmd_msk) | (cmd_dir & cmd_msk);
    assign wr_out    = (cur_out & ~cmd_msk) | (cmd_db & cmd_msk);
    assign sync_bank = sync_q[SYNC_STAGES-1][int'(bank_q)*UNIT_NBIT +: UNIT_NBIT];

`ifdef IOBANK_PULSE_EN
    localparam logic [1:0] OP_PL = 2'd2;

    logic [PULSE_NBIT-1:0]  cnt_q, cnt_d;
    logic [UNIT_NBIT-1:0]   sv_oe_q, sv_oe_d, sv_out_q, sv_out_d, sv_msk_q, sv_msk_d;
    logic [UNIT_NBIT-1:0]   pb_oe, pb_out, rs_oe, rs_out;

    // Restore only the bits the pulse forced; the rest of the bank is untouched.
    assign pb_oe  = oe_q[int'(bank_q)*UNIT_NBIT +: UNIT_NBIT];
    assign pb_out = out_q[int'(bank_q)*UNIT_NBIT +: UNIT_NBIT];
    assign rs_oe  = (pb_oe & ~sv_msk_q) | (sv_oe_q & sv_msk_q);
    assign rs_out = (pb_out & ~sv_msk_q) | (sv_out_q & sv_msk_q);

    // Pulse counter and saved pin state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sv_oe_q  <= '0;
            sv_out_q <= '0;
            sv_msk_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sv_oe_q  <= sv_oe_d;
            sv_out_q <= sv_out_d;
            sv_msk_q <= sv_msk_d;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^cmd_len;
`endif

    // Pad input synchroniser, free-running regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // FSM state, pin registers and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            oe_q      <= '0;
            out_q     <= '0;
            bank_q    <= '0;
            rsp_err_q <= 1'b0;
            rsp_db_q  <= '0;
        end else begin
            state_q   <= state_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            bank_q    <= bank_d;
            rsp_err_q <= rsp_err_d;
            rsp_db_q  <= rsp_db_d;
        end
    end

    // Command decode, pin updates and next-state selection.
    always_comb begin
        state_d   = state_q;
        oe_d      = oe_q;
        out_d     = out_q;
        bank_d    = bank_q;
        rsp_err_d = rsp_err_q;
        rsp_db_d  = rsp_db_q;
`ifdef IOBANK_PULSE_EN
        cnt_d     = cnt_q;
        sv_oe_d   = sv_oe_q;
        sv_out_d  = sv_out_q;
        sv_msk_d  = sv_msk_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bank_d    = cmd_bank;
                    rsp_err_d = 1'b0;
                    rsp_db_d  = '0;
                    state_d   = RESP;
                    if (bank_bad) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_WR: begin
                                oe_d[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT]  = wr_oe;
                                out_d[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT] = wr_out;
                                rsp_db_d = wr_out;
                            end
                            OP_RD: state_d = RD;
`ifdef IOBANK_PULSE_EN
                            OP_PL: begin
                                sv_oe_d  = cur_oe;
                                sv_out_d = cur_out;
                                sv_msk_d = cmd_msk;
                                oe_d[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT]  = cur_oe | cmd_msk;
                                out_d[int'(cmd_bank)*UNIT_NBIT +: UNIT_NBIT] = wr_out;
                                // len 0 behaves as len 1: counter holds remaining cycles after the first.
                                cnt_d    = (cmd_len == '0) ? '0 : cmd_len - 1'b1;
                                state_d  = PULSE;
                            end
`endif
                            default: rsp_err_d = 1'b1;
                        endcase
                    end
                end
            end
            RD: begin
                rsp_db_d = sync_bank;
                state_d  = RESP;
            end
`ifdef IOBANK_PULSE_EN
            PULSE: begin
                if (cnt_q == '0) begin
                    oe_d[int'(bank_q)*UNIT_NBIT +: UNIT_NBIT]  = rs_oe;
                    out_d[int'(bank_q)*UNIT_NBIT +: UNIT_NBIT] = rs_out;
                    rsp_db_d = rs_out;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_vd  = (state_q == RESP);
    assign rsp_err = rsp_vd & rsp_err_q;
    assign rsp_db  = rsp_vd ? rsp_db_q : '0;
    assign io_oe   = oe_q;
    assign io_out  = out_q;
endmodule

// File: doc/io_bank_ctrl.md
Name: io_bank_ctrl

Overview:
- Parametrised general-purpose IO bank controller; successor to the fixed two-bank IO handling (bank 0 tri-state IO, bank 1 enables) in the top level.
- Serves NBANK banks of UNIT_NBIT pins each through one command/response handshake from the packet decoder.
- Adds per-bit write masks, synchronised read-back, timed output pulses and out-of-range bank error reporting.
- Sits between pkt_decode and the tri-state pad assignments in the top level.

Parameters:
- NBANK, 4, number of IO banks.
- UNIT_NBIT, 16, pins per bank.
- BANK_NBIT, 2, width of bank select; must satisfy 2^BANK_NBIT >= NBANK.
- PULSE_NBIT, 16, width of pulse length field.
- SYNC_STAGES, 2, input synchroniser depth; minimum 2.

Ports:
- clk  in  1  system clock (mclk domain).
- rst  in  1  synchronous reset, active-high.
- cmd_vd  in  1  command valid; held by source until accepted.
- cmd_rdy  out  1  controller ready; a command is accepted on an edge where cmd_vd & cmd_rdy.
- cmd_op  in  2  0=write, 1=read, 2=pulse, 3=reserved.
- cmd_bank  in  BANK_NBIT  target bank.
- cmd_msk  in  UNIT_NBIT  per-bit update mask for write/pulse.
- cmd_dir  in  UNIT_NBIT  direction for masked bits (1=drive).
- cmd_db  in  UNIT_NBIT  output value for masked bits.
- cmd_len  in  PULSE_NBIT  pulse width in clk cycles.
- rsp_vd  out  1  one-cycle response strobe.
- rsp_err  out  1  error flag, valid with rsp_vd.
- rsp_db  out  UNIT_NBIT  response data, valid with rsp_vd.
- io_oe  out  NBANK*UNIT_NBIT  per-pin output enable; bank b occupies bits [b*UNIT_NBIT +: UNIT_NBIT].
- io_out  out  NBANK*UNIT_NBIT  per-pin output value.
- io_in  in  NBANK*UNIT_NBIT  raw pad inputs (asynchronous).

Behaviour:
Reset:
- io_oe=0 (all pins tri-state), io_out=0, rsp_vd=0, rsp_err=0, rsp_db=0, cmd_rdy=0 during rst, state=IDLE.
- Synchroniser chain cleared to 0.
- Reset mid-pulse aborts the pulse and emits no response.

Synchroniser:
- io_in passes through SYNC_STAGES flops continuously, independent of state.

FSM states: IDLE, RD, PULSE, RESP.
- cmd_rdy=1 only in IDLE; cmd_vd in any other state is ignored (source holds).

WRITE (op 0), accepted at edge T:
- At T, for bits with cmd_msk[i]=1: oe[i]<=cmd_dir[i], out[i]<=cmd_db[i]; unmasked bits unchanged.
- State goes to RESP. In cycle T+1: rsp_vd=1, rsp_db=new out value of bank, rsp_err=0. Then IDLE.

READ (op 1):
- State goes to RD (one settle cycle), then RESP.
- rsp_db = synchronised pins of bank, i.e. pad level after SYNC_STAGES; no oe masking.
- rsp_vd is asserted in cycle T+2.

PULSE (op 2):
- At T, save current oe/out of masked bits; force oe=1 and out=cmd_db on masked bits.
- Load counter with max(cmd_len,1)-1; state goes to PULSE.
- In PULSE, decrement each cycle. When counter==0, restore saved oe/out on masked bits and go to RESP.
- Driven width is exactly max(cmd_len,1) cycles.
- rsp_db = restored out value of bank.

Errors:
- cmd_bank >= NBANK, or op 3: no pin change; RESP with rsp_err=1, rsp_db=0.
- cmd_msk=0 on write/pulse: legal. Pins are unchanged but timing is unchanged (pulse still waits its length).

Arithmetic:
- Counter is PULSE_NBIT unsigned with no wrap. cmd_len=0 is treated as 1.

Optional Feature:
- Macro IOBANK_PULSE_EN.
- Defined: op 2 behaves as the pulse op above.
- Undefined: PULSE state, counter and save registers are not built; op 2 is treated as reserved (rsp_err=1, no pin change, response at T+1).

Test Plan:
- Reset, then write bank 2, msk=0x00FF, dir=0x00FF, db=0x00A5 -> io_oe[47:32]=0x00FF, io_out[47:32]=0x00A5; rsp_vd at T+1, rsp_db=0x00A5, rsp_err=0; other banks remain 0.
- Drive io_in bank 1 = 0x1234, then read bank 1 -> rsp_vd at T+2 with rsp_db=0x1234. Change io_in one cycle before accept -> old value returned when SYNC_STAGES=2.
- Pulse bank 0, msk=0x0001, db=0x0001, len=5, prior oe=out=0 -> pin 0 oe/out high for exactly 5 cycles, then 0; rsp_vd the cycle after restore. Repeat with len=0 -> 1-cycle pulse.
- Command with cmd_bank=3 when NBANK=3, or op=3 -> rsp_err=1, rsp_db=0, no change on io_oe/io_out.
- Assert rst during a len=100 pulse at count 50 -> next cycle all io_oe/io_out=0, no rsp_vd, cmd_rdy=1 after rst deasserts.
- Back-to-back: hold cmd_vd with two writes -> second accepted 2 cycles after first; cmd_rdy low in between. Build with IOBANK_PULSE_EN undefined -> op 2 gives rsp_err=1 at T+1.
